// File: rtl/secded_scrub_ctrl.sv
// Memory scrubber: walks every word, checks it through an external SECDED decoder,
// rewrites single-bit-corrected words and logs uncorrectable ones.
module secded_scrub_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic [6:0]        o_dec_data,
    output logic              o_dec_parity,
    input  logic [3:0]        i_dec_data,
    input  logic              i_dec_1bit,
    input  logic              i_dec_2bit,
    output logic [3:0]        o_enc_data,
    input  logic [6:0]        i_enc_code,
    input  logic              i_enc_parity,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_uncorr_cnt,
    output logic              o_uncorr_seen,
    output logic [ADDR_W-1:0] o_first_uncorr_addr,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        EVAL  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mem_re;
    logic                r_mem_we;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_corr_cnt;
    logic [CNT_W-1:0]    r_uncorr_cnt;
    logic                r_uncorr_seen;
    logic [ADDR_W-1:0]   r_first_addr;
    logic [7:0]          r_rd_q;
    logic [3:0]          r_wb_q;
    logic                w_last;

    assign w_last = (r_addr == ADDR_LAST);

    // Memory strobes are single-cycle: o_mem_re in READ (data returns next cycle),
    // o_mem_we in WRITE (memory captures o_mem_wdata on the closing edge).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_mem_re      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_corr_cnt    <= '0;
            r_uncorr_cnt  <= '0;
            r_uncorr_seen <= 1'b0;
            r_first_addr  <= '0;
            r_rd_q        <= '0;
            r_wb_q        <= '0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            if (i_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_state       <= READ;
                            r_addr        <= '0;
                            r_corr_cnt    <= '0;
                            r_uncorr_cnt  <= '0;
                            r_uncorr_seen <= 1'b0;
                            r_first_addr  <= '0;
                            r_mem_re      <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                    READ: begin
                        r_state <= LATCH;
                    end
                    LATCH: begin
                        r_rd_q  <= i_mem_rdata;
                        r_state <= EVAL;
                    end
                    EVAL: begin
                        r_wb_q <= i_dec_data;
                        if (i_dec_2bit) begin
                            if (r_uncorr_cnt != CNT_MAX) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
                            if (!r_uncorr_seen) begin
                                r_uncorr_seen <= 1'b1;
                                r_first_addr  <= r_addr;
                            end
                        end
                        if (i_dec_1bit && !i_dec_2bit) begin
                            if (r_corr_cnt != CNT_MAX) r_corr_cnt <= r_corr_cnt + CNT_W'(1);
                            r_state  <= WRITE;
                            r_mem_we <= 1'b1;
                        end else if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_state  <= READ;
                            r_mem_re <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_state  <= READ;
                            r_mem_re <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_mem_addr          = r_addr;
    assign o_mem_re            = r_mem_re;
    assign o_mem_we            = r_mem_we;
    assign o_mem_wdata         = {i_enc_parity, i_enc_code};
    assign o_dec_data          = r_rd_q[6:0];
    assign o_dec_parity        = r_rd_q[7];
    assign o_enc_data          = r_wb_q;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_corr_cnt          = r_corr_cnt;
    assign o_uncorr_cnt        = r_uncorr_cnt;
    assign o_uncorr_seen       = r_uncorr_seen;
    assign o_first_uncorr_addr = r_first_addr;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Bench for secded_scrub_ctrl: memory, Hamming(7,4)+parity codec models and a
// pass-level reference built from the injected error masks.
module tb_secded_scrub_ctrl;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;
    localparam int N      = 16;
    localparam int CMAX   = 3;

    logic              clk, rst, i_start, i_abort;
    logic [ADDR_W-1:0] mem_addr, first_addr;
    logic              mem_re, mem_we, dec_par, busy, done, useen;
    logic [7:0]        mem_rdata, mem_wdata;
    logic [6:0]        dec_code;
    logic [3:0]        dec_d, enc_d;
    logic              dec_1, dec_2;
    logic [6:0]        enc_code;
    logic              enc_par;
    logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
    logic [2:0]        dbg_state;

    logic [7:0]  mem[N];
    logic [7:0]  load_img[N];
    logic        load_en;
    logic [3:0]  wdat[N];
    logic [7:0]  wmask[N];
    logic [11:0] exp_q[$];
    int total, bad, n_re, n_we, n_done;

    secded_scrub_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .o_mem_addr(mem_addr), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata),
        .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .o_dec_data(dec_code), .o_dec_parity(dec_par), .i_dec_data(dec_d),
        .i_dec_1bit(dec_1), .i_dec_2bit(dec_2),
        .o_enc_data(enc_d), .i_enc_code(enc_code), .i_enc_parity(enc_par),
        .o_busy(busy), .o_done(done), .o_corr_cnt(corr_cnt), .o_uncorr_cnt(uncorr_cnt),
        .o_uncorr_seen(useen), .o_first_uncorr_addr(first_addr), .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc8(input logic [3:0] d);
        logic [6:0] c;
        c = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
        return {^c, c};
    endfunction

    // external codec models
    logic [7:0] enc_w;
    assign enc_w    = enc8(enc_d);
    assign enc_code = enc_w[6:0];
    assign enc_par  = enc_w[7];

    logic [2:0] syn;
    logic       pbad;
    logic [6:0] cfix;
    always_comb begin
        syn = 3'd0;
        for (int i = 1; i <= 7; i++) if (dec_code[i-1]) syn = syn ^ 3'(i);
        pbad = ^{dec_par, dec_code};
        cfix = dec_code;
        if (pbad && syn != 3'd0) cfix[syn-1] = ~cfix[syn-1];
        dec_1 = pbad;
        dec_2 = !pbad && (syn != 3'd0);
        dec_d = {cfix[6], cfix[5], cfix[4], cfix[2]};
    end

    // memory
    always @(posedge clk) begin
        if (load_en) mem <= load_img;
        else begin
            if (mem_re) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // scoreboard on the write port
    always @(negedge clk) begin
        logic [11:0] e;
        if (mem_re) n_re++;
        if (done) n_done++;
        if (mem_we) begin
            n_we++;
            check("re_we_excl", mem_re, 0);
            if (exp_q.size() == 0) check("write_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[11:8]);
                check("wr_data", mem_wdata, e[7:0]);
            end
        end
    end

    task automatic check_reset(input string nm);
        check({nm, "_addr"}, mem_addr, 0);
        check({nm, "_re"}, mem_re, 0);
        check({nm, "_we"}, mem_we, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_corr"}, corr_cnt, 0);
        check({nm, "_uncorr"}, uncorr_cnt, 0);
        check({nm, "_seen"}, useen, 0);
        check({nm, "_first"}, first_addr, 0);
        check({nm, "_rdq"}, {dec_par, dec_code}, 0);
        check({nm, "_wbq"}, enc_d, 0);
    endtask

    // driver tasks
    task automatic set_clean();
        for (int i = 0; i < N; i++) begin
            wdat[i]  = 4'(i);
            wmask[i] = 8'h00;
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) load_img[i] = enc8(wdat[i]) ^ wmask[i];
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run_pass(input string nm);
        int ncorr, nunc, first, cyc, mism, nf;
        logic [7:0] exp_img[N];
        ncorr = 0; nunc = 0; first = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            nf = $countones(wmask[i]);
            exp_img[i] = enc8(wdat[i]) ^ wmask[i];
            if (nf == 1) begin
                ncorr++;
                exp_img[i] = enc8(wdat[i]);
                exp_q.push_back({4'(i), enc8(wdat[i])});
            end else if (nf == 2) begin
                if (nunc == 0) first = i;
                nunc++;
            end
        end
        load_mem();
        n_re = 0; n_we = 0; n_done = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            i_start = (cyc == 10);
        end
        i_start = 1'b0;
        check({nm, "_done_seen"}, done, 1);
        check({nm, "_cycles"}, cyc, 48 + ncorr);
        check({nm, "_busy_at_done"}, busy, 1);
        check({nm, "_corr"}, corr_cnt, (ncorr > CMAX) ? CMAX : ncorr);
        check({nm, "_uncorr"}, uncorr_cnt, (nunc > CMAX) ? CMAX : nunc);
        check({nm, "_seen"}, useen, (nunc > 0));
        check({nm, "_first"}, first_addr, first);
        check({nm, "_reads"}, n_re, N);
        check({nm, "_writes"}, n_we, ncorr);
        check({nm, "_exp_left"}, exp_q.size(), 0);
        mism = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== exp_img[i]) mism++;
        check({nm, "_image"}, mism, 0);
        @(negedge clk);
        check({nm, "_idle_busy"}, busy, 0);
        check({nm, "_done_pulse"}, n_done, 1);
        check({nm, "_held_corr"}, corr_cnt, (ncorr > CMAX) ? CMAX : ncorr);
    endtask

    initial begin
        int cyc, seen_re, snap_re, snap_we, b1;
        total = 0; bad = 0; n_re = 0; n_we = 0; n_done = 0;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; load_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        set_clean();
        run_pass("clean");

        set_clean();
        wmask[5] = 8'h04;
        run_pass("single5");

        set_clean();
        wmask[3] = 8'h11;
        wmask[9] = 8'h06;
        run_pass("double39");

        set_clean();
        for (int i = 0; i < 5; i++) wmask[2 + 3*i] = 8'h01 << i;
        run_pass("sat5");

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                wdat[i] = 4'($urandom_range(0, 15));
                r  = $urandom_range(0, 9);
                b1 = $urandom_range(0, 7);
                wmask[i] = 8'h00;
                if (r >= 6) wmask[i] = 8'h01 << b1;
                if (r >= 8) wmask[i] = wmask[i] | (8'h01 << ((b1 + $urandom_range(1, 7)) % 8));
            end
            run_pass($sformatf("rand%0d", p));
        end

        // abort while writing word 7, start asserted alongside
        set_clean();
        wmask[7] = 8'h20;
        exp_q.delete();
        exp_q.push_back({4'd7, enc8(4'd7)});
        load_mem();
        n_re = 0; n_we = 0; n_done = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (!(mem_we && mem_addr == 4'd7) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            i_start = (cyc == 5);
        end
        check("abort_reach_write", mem_we && mem_addr == 4'd7, 1);
        i_abort = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_we", mem_we, 0);
        check("abort_mem7", mem[7], enc8(4'd7));
        check("abort_writes", n_we, 1);
        check("abort_corr", corr_cnt, 1);
        snap_re = n_re;
        repeat (5) @(negedge clk);
        check("abort_no_done", n_done, 0);
        check("abort_no_reads", n_re, snap_re);
        check("abort_exp_left", exp_q.size(), 0);

        // asynchronous reset during LATCH of word 1
        set_clean();
        wmask[0] = 8'h03;
        exp_q.delete();
        load_mem();
        n_re = 0; n_we = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen_re = mem_re ? 1 : 0;
        cyc = 0;
        while (seen_re < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_re) seen_re++;
        end
        check("rst_reach_read1", seen_re, 2);
        @(negedge clk);
        check("rst_pre_uncorr", uncorr_cnt, 1);
        check("rst_pre_seen", useen, 1);
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        snap_re = n_re;
        snap_we = n_we;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_reads", n_re, snap_re);
        check("rst_no_writes", n_we, snap_we);
        check("rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
